// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding-request fetcher feeding a QDEPTH-entry queue.
// Define FETCH_STALLCNT_EN to add the saturating stall_cnt output.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
`ifdef FETCH_STALLCNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam int unsigned PW = (QDEPTH > 2) ? 2 : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(QDEPTH);

  typedef enum logic [1:0] {
    S_RUN,
    S_WAIT,
    S_FLUSH
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;

  logic [QDEPTH-1:0][31:0] instr_mem_q;
  logic [QDEPTH-1:0][31:0] pc_mem_q;
  logic [PW-1:0]           rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]           count_q, count_d;

  logic push;
  logic pop;

  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready & ~redirect;
  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign out_instr = instr_mem_q[rd_ptr_q];
  assign out_pc    = pc_mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    push       = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (!redirect && (count_q < DEPTH)) begin
          req_d   = 1'b1;
          addr_d  = fetch_pc_q;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          req_d   = 1'b0;
          state_d = S_RUN;
          if (!redirect) begin
            push       = 1'b1;
            fetch_pc_d = addr_q + 32'd4;
          end
        end else if (redirect) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (imem_ack) begin
          req_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
    // A redirect overrides any sequential PC advance, whatever the state.
    if (redirect) fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
  end

  always_comb begin
    count_d = count_q;
    if (redirect) begin
      count_d = '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RUN;
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      // NOTE: queue storage is reset because the head entry drives out_instr/out_pc directly.
      instr_mem_q <= '0;
      pc_mem_q    <= '0;
    end else begin
      count_q <= count_d;
      if (redirect) begin
        rd_ptr_q <= wr_ptr_q;
      end else begin
        if (push) begin
          instr_mem_q[wr_ptr_q] <= imem_rdata;
          pc_mem_q[wr_ptr_q]    <= addr_q;
          wr_ptr_q              <= wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

`ifdef FETCH_STALLCNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (!out_valid && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic, all checked against a
// queue-level reference model; a second instance covers the wrapping reset PC.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam int          QD  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
`ifdef FETCH_STALLCNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] w_stall;
`endif

  logic        w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pc;
  logic        w_ack = 1'b0;
  logic [31:0] w_addrs[$];

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;
  int fixed_lat = 1;
  bit rand_lat = 1'b0;
  bit junk_ack = 1'b0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  bit          m_out = 1'b0;
  bit          m_drop = 1'b0;
  logic [31:0] m_fpc = RPC;
  logic [31:0] m_addr = '0;
  logic [31:0] m_stall = '0;
  int          wait_cnt = 0;
  int          cur_lat = 1;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc)
`ifdef FETCH_STALLCNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .QDEPTH(2)) dut_wrap (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (w_req),
    .imem_addr  (w_addr),
    .imem_ack   (w_ack),
    .imem_rdata (~w_addr),
    .redirect   (1'b0),
    .redirect_pc(32'h0),
    .out_valid  (w_valid),
    .out_ready  (1'b1),
    .out_instr  (w_instr),
    .out_pc     (w_pc)
`ifdef FETCH_STALLCNT_EN
    ,
    .stall_cnt  (w_stall)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one fetch in flight, an ordered list of fetched words, and a flag that
  // marks the in-flight fetch as stale once a redirect has overtaken it.
  task automatic model_step();
    int sz0;
    bit ack_now;
    if (rst) begin
      mq.delete();
      m_out   = 1'b0;
      m_drop  = 1'b0;
      m_fpc   = RPC;
      m_addr  = '0;
      m_stall = '0;
    end else begin
      sz0 = mq.size();
      if (sz0 == 0 && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
      ack_now = imem_ack && m_out;
      if (redirect) begin
        mq.delete();
        m_fpc = redirect_pc & 32'hFFFF_FFFC;
        if (ack_now) begin
          m_out  = 1'b0;
          m_drop = 1'b0;
        end else if (m_out) begin
          m_drop = 1'b1;
        end
      end else begin
        if (sz0 > 0 && out_ready) void'(mq.pop_front());
        if (ack_now) begin
          if (!m_drop) begin
            mq.push_back({imem_rdata, m_addr});
            m_fpc = m_addr + 32'd4;
          end
          m_out  = 1'b0;
          m_drop = 1'b0;
        end else if (!m_out && sz0 < QD) begin
          m_out  = 1'b1;
          m_addr = m_fpc;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Memory responder: answers the request the model says is in flight.
  initial forever begin
    @(negedge clk);
    if (m_out) begin
      wait_cnt++;
      if (wait_cnt == 1) cur_lat = rand_lat ? int'($urandom_range(1, 4)) : fixed_lat;
      imem_ack   = (wait_cnt >= cur_lat);
      imem_rdata = imem_ack ? mem_word(m_addr) : $urandom;
    end else begin
      wait_cnt   = 0;
      imem_ack   = junk_ack && ($urandom_range(0, 3) == 0);
      imem_rdata = $urandom;
    end
  end

  initial forever begin
    @(negedge clk);
    w_ack = (w_req === 1'b1) && !w_ack;
    if (w_ack) w_addrs.push_back(w_addr);
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      check("req", imem_req, m_out);
      if (m_out) check("addr", imem_addr, m_addr);
      check("valid", out_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        check("head_pc", out_pc, mq[0].pc);
        check("head_instr", out_instr, mq[0].instr);
      end
`ifdef FETCH_STALLCNT_EN
      check("stall", stall_cnt, m_stall);
`endif
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask

  initial begin
    int got;
    int n_acks;
    bit seen_req, seen_out, w_seen, prev_req;

    repeat (2) step();
    cmp_en = 1'b1;
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_valid", out_valid, 0);
    check("rst_instr", out_instr, 0);
    check("rst_pc", out_pc, 0);

    // Streaming fetch from reset, one-cycle memory, decoder always ready.
    out_ready = 1'b1;
    fixed_lat = 1;
    w_addrs.delete();
    w_seen = 1'b0;
    rst = 1'b0;
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      step();
      if (cyc == 0) begin
        check("t1_first_req", imem_req, 1);
        check("t1_first_addr", imem_addr, RPC);
      end
      if (w_valid && !w_seen) begin
        w_seen = 1'b1;
        check("wrap_first_pc", w_pc, 32'hFFFF_FFFC);
        check("wrap_first_instr", w_instr, 32'h0000_0003);
      end
      if (out_valid && out_ready) begin
        check("t1_pc", out_pc, 32'(got * 4));
        check("t1_instr", out_instr, mem_word(32'(got * 4)));
        got++;
      end
    end
    check("t1_count", 32'(got), 4);
    check("wrap_reqs", 32'(w_addrs.size() >= 2), 1);
    if (w_addrs.size() >= 2) begin
      check("wrap_addr0", w_addrs[0], 32'hFFFF_FFFC);
      check("wrap_addr1", w_addrs[1], 32'h0000_0000);
    end

    // Back-pressure: queue fills after two fetches and issuing stops.
    out_ready = 1'b0;
    do_reset();
    n_acks = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      step();
      if (n_acks == 2) check("t2_req_idle", imem_req, 0);
      if (imem_req && imem_ack) n_acks++;
      if (out_valid) check("t2_pc_hold", out_pc, 0);
    end
    check("t2_acks", 32'(n_acks), 2);
    out_ready = 1'b1;
    step();
    check("t2_pop_pc", out_pc, 32'h4);

    // Redirect while waiting; the stale ack lands three cycles later.
    fixed_lat = 4;
    do_reset();
    step();
    check("t3_req", imem_req, 1);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    step();
    redirect = 1'b0;
    prev_req = imem_req;
    seen_req = 1'b0;
    seen_out = 1'b0;
    for (int cyc = 0; cyc < 30 && !seen_out; cyc++) begin
      step();
      if (imem_req && !prev_req && !seen_req) begin
        seen_req = 1'b1;
        check("t3_req_addr", imem_addr, 32'h0000_0100);
      end
      prev_req = imem_req;
      if (out_valid) begin
        seen_out = 1'b1;
        check("t3_first_pc", out_pc, 32'h0000_0100);
        check("t3_first_instr", out_instr, mem_word(32'h0000_0100));
      end
    end
    check("t3_saw_req", seen_req, 1);
    check("t3_saw_out", seen_out, 1);

    // Redirect coinciding with an ack and a pop.
    fixed_lat = 1;
    out_ready = 1'b0;
    do_reset();
    step();
    step();
    check("t4_valid", out_valid, 1);
    step();
    check("t4_ack_req", {imem_req, imem_ack}, 2'b11);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0042;
    out_ready   = 1'b1;
    step();
    redirect = 1'b0;
    check("t4_empty", out_valid, 0);
    check("t4_req_drop", imem_req, 0);
    step();
    check("t4_req", imem_req, 1);
    check("t4_addr", imem_addr, 32'h0000_0040);

`ifdef FETCH_STALLCNT_EN
    // Stall counter with a five-cycle memory.
    fixed_lat = 5;
    do_reset();
    seen_out = 1'b0;
    for (int cyc = 0; cyc < 20 && !seen_out; cyc++) begin
      step();
      if (out_valid) begin
        seen_out = 1'b1;
        check("t6_stall", stall_cnt, 32'd6);
      end
    end
    check("t6_saw_out", seen_out, 1);
`endif

    // Random traffic: latency, back-pressure, redirects, stray acks and resets.
    rand_lat = 1'b1;
    junk_ack = 1'b1;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      out_ready = ($urandom_range(0, 3) != 0);
      redirect  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | $urandom_range(0, 15);
      else redirect_pc = $urandom;
      rst = ($urandom_range(0, 199) == 0);
    end
    rst      = 1'b0;
    redirect = 1'b0;
    junk_ack = 1'b0;
    rand_lat = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
